imgproc_msg_reader: RTL



---
 rtl/imgproc_msg_reader.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/imgproc_msg_reader.sv
// imgproc_msg_reader
//
// Avalon-MM master that drains the bounding-box message FIFO of the
// image-processing slave. After checking the slave ID, it polls the status
// register. When a complete 11-word "RBB" message is queued, it reads the
// message into a shadow buffer and validates every word. A good message is
// published to res_* in a single cycle, with a res_valid pulse. A malformed
// message flushes the slave FIFO and bumps err_count.
//
// Ports
//   clk, reset_n      clock, synchronous active-low reset
//   enable            allow status polling (sampled only while waiting)
//   m_chipselect, m_read, m_write, m_address, m_writedata
//                     Avalon-MM master command outputs (all registered)
//   m_readdata        slave read data, valid one cycle after the read strobe
//   res_cx/cy/w/h     5 x 11-bit fields; colour k at [11k+10:11k]
//                     (red, green, blue, grey, yellow)
//   res_present       bit k set when colour k lies inside the image
//   res_valid         one-cycle pulse when res_* is updated
//   err_count         malformed messages seen, saturating at 255
//   id_error          slave ID mismatch; the block is halted
//   busy              high while a bus transaction sequence is in progress
module imgproc_msg_reader #(
  parameter int unsigned POLL_CYCLES = 1024,
  parameter int unsigned MSG_WORDS   = 11,
  parameter int unsigned IMAGE_W     = 640,
  parameter int unsigned IMAGE_H     = 480,
  parameter logic [31:0] EXPECTED_ID = 32'h1234EEE2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [54:0] res_cx,
  output logic [54:0] res_cy,
  output logic [54:0] res_w,
  output logic [54:0] res_h,
  output logic [4:0]  res_present,
  output logic        res_valid,
  output logic [7:0]  err_count,
  output logic        id_error,
  output logic        busy
);

  localparam int unsigned NCOL  = 5;
  localparam int unsigned SH_N  = 2 * NCOL;
  localparam int unsigned CNT_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned IDX_W = $clog2(MSG_WORDS);

  localparam logic [2:0]  ADDR_STAT = 3'd0;
  localparam logic [2:0]  ADDR_MSG  = 3'd1;
  localparam logic [2:0]  ADDR_ID   = 3'd2;
  localparam logic [31:0] HEADER    = 32'h00524242;
  localparam logic [31:0] FLUSH_CMD = 32'h00000010;

  typedef enum logic [3:0] {
    S_RD_ID, S_CAP_ID, S_POLL_WAIT, S_RD_STAT, S_CAP_STAT,
    S_RD_MSG, S_CAP_MSG, S_FLUSH, S_COMMIT, S_HALT
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               cs_q, rd_q, wr_q;
  logic [2:0]         addr_q;
  logic [31:0]        wdata_q;
  logic [54:0]        res_cx_q, res_cy_q, res_w_q, res_h_q;
  logic [4:0]         res_present_q;
  logic               res_valid_q;
  logic [7:0]         err_count_q;
  logic               id_error_q;
  logic               busy_q;

  // Only the two 11-bit fields of each body word are kept: {[26:16], [10:0]}.
  logic [21:0]        shadow_q [SH_N];

  logic [54:0]        res_cx_d, res_cy_d, res_w_d, res_h_d;
  logic [4:0]         res_present_d;
  logic [7:0]         err_count_d;
  logic               word_ok;
  logic [IDX_W-1:0]   sh_idx;

  assign err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
  assign sh_idx      = idx_q - IDX_W'(1);

  always_comb begin
    word_ok = 1'b0;
    if (idx_q == '0) begin
      word_ok = (m_readdata == HEADER);
    end else begin
      word_ok = (m_readdata[31:27] == 5'd0) && (m_readdata[15:11] == 5'd0);
    end
  end

  // Shadow entry 2k holds {cx, cy} and entry 2k+1 holds {h, w} for colour k.
  always_comb begin
    res_cx_d      = '0;
    res_cy_d      = '0;
    res_w_d       = '0;
    res_h_d       = '0;
    res_present_d = '0;
    for (int k = 0; k < NCOL; k++) begin
      res_cx_d[11*k +: 11] = shadow_q[2*k][21:11];
      res_cy_d[11*k +: 11] = shadow_q[2*k][10:0];
      res_h_d[11*k +: 11]  = shadow_q[2*k+1][21:11];
      res_w_d[11*k +: 11]  = shadow_q[2*k+1][10:0];
      res_present_d[k]     = (shadow_q[2*k+1][10:0] < 11'(IMAGE_W)) &&
                             (shadow_q[2*k+1][21:11] < 11'(IMAGE_H));
    end
  end

  // The shadow buffer is data only; it is fully rewritten before any commit.
  always_ff @(posedge clk) begin
    if (state_q == S_CAP_MSG && idx_q != '0 && idx_q <= IDX_W'(SH_N)) begin
      shadow_q[sh_idx] <= {m_readdata[26:16], m_readdata[10:0]};
    end
  end

  // Bus outputs are registered: each transition into an RD_*/FLUSH state
  // raises the strobe for exactly that state's cycle, so reads are always
  // separated by a capture cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_RD_ID;
      cnt_q         <= '0;
      idx_q         <= '0;
      cs_q          <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      res_cx_q      <= '0;
      res_cy_q      <= '0;
      res_w_q       <= '0;
      res_h_q       <= '0;
      res_present_q <= '0;
      res_valid_q   <= 1'b0;
      err_count_q   <= '0;
      id_error_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        // Leaving reset the strobes are low, so the first RD_ID cycle
        // raises the ID read and the second one completes it.
        S_RD_ID: begin
          if (!rd_q) begin
            cs_q   <= 1'b1;
            rd_q   <= 1'b1;
            addr_q <= ADDR_ID;
            busy_q <= 1'b1;
          end else begin
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            state_q <= S_CAP_ID;
          end
        end
        S_CAP_ID: begin
          busy_q <= 1'b0;
          if (m_readdata == EXPECTED_ID) begin
            cnt_q   <= CNT_W'(POLL_CYCLES - 1);
            state_q <= S_POLL_WAIT;
          end else begin
            id_error_q <= 1'b1;
            state_q    <= S_HALT;
          end
        end
        S_POLL_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (enable) begin
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= ADDR_STAT;
            busy_q  <= 1'b1;
            state_q <= S_RD_STAT;
          end
        end
        S_RD_STAT: begin
          cs_q    <= 1'b0;
          rd_q    <= 1'b0;
          addr_q  <= '0;
          state_q <= S_CAP_STAT;
        end
        S_CAP_STAT: begin
          if (m_readdata[15:8] >= 8'(MSG_WORDS)) begin
            idx_q   <= '0;
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= ADDR_MSG;
            state_q <= S_RD_MSG;
          end else begin
            busy_q  <= 1'b0;
            cnt_q   <= CNT_W'(POLL_CYCLES - 1);
            state_q <= S_POLL_WAIT;
          end
        end
        S_RD_MSG: begin
          cs_q    <= 1'b0;
          rd_q    <= 1'b0;
          addr_q  <= '0;
          state_q <= S_CAP_MSG;
        end
        S_CAP_MSG: begin
          if (!word_ok) begin
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= ADDR_STAT;
            wdata_q <= FLUSH_CMD;
            state_q <= S_FLUSH;
          end else if (idx_q == IDX_W'(MSG_WORDS - 1)) begin
            state_q <= S_COMMIT;
          end else begin
            idx_q   <= idx_q + IDX_W'(1);
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= ADDR_MSG;
            state_q <= S_RD_MSG;
          end
        end
        S_FLUSH: begin
          cs_q        <= 1'b0;
          wr_q        <= 1'b0;
          addr_q      <= '0;
          wdata_q     <= '0;
          err_count_q <= err_count_d;
          busy_q      <= 1'b0;
          cnt_q       <= CNT_W'(POLL_CYCLES - 1);
          state_q     <= S_POLL_WAIT;
        end
        S_COMMIT: begin
          res_cx_q      <= res_cx_d;
          res_cy_q      <= res_cy_d;
          res_w_q       <= res_w_d;
          res_h_q       <= res_h_d;
          res_present_q <= res_present_d;
          res_valid_q   <= 1'b1;
          busy_q        <= 1'b0;
          cnt_q         <= CNT_W'(POLL_CYCLES - 1);
          state_q       <= S_POLL_WAIT;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_RD_ID;
        end
      endcase
    end
  end

  assign m_chipselect = cs_q;
  assign m_read       = rd_q;
  assign m_write      = wr_q;
  assign m_address    = addr_q;
  assign m_writedata  = wdata_q;
  assign res_cx       = res_cx_q;
  assign res_cy       = res_cy_q;
  assign res_w        = res_w_q;
  assign res_h        = res_h_q;
  assign res_present  = res_present_q;
  assign res_valid    = res_valid_q;
  assign err_count    = err_count_q;
  assign id_error     = id_error_q;
  assign busy         = busy_q;

endmodule
